uart_rx_cfg: RTL and testbench
==============================

UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter UART_BPS, default 9600, line baud rate.
REQ-003 SHALL have parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-004 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-005 SHALL have parameter STOP_BITS, default 1, stop bits checked; legal values 1, 2.
REQ-006 SHALL have parameter FIFO_DEPTH, default 8, receive FIFO entries; power of two, 2..64.
REQ-007 SHALL have port sys_clk, input, 1, single clock; all logic on its rising edge.
REQ-008 SHALL have port sys_rst, input, 1, reset, asynchronous assert, active-high.
REQ-009 SHALL have port rx, input, 1, asynchronous serial line, idle high.
REQ-010 SHALL have port rx_data, output, DATA_BITS, received word, LSB = first data bit.
REQ-011 SHALL have port rx_valid, output, 1, rx_data holds an unread word.
REQ-012 SHALL have port rx_ready, input, 1, consumer accepts the word when rx_valid && rx_ready.
REQ-013 SHALL have port parity_err, output, 1, one-cycle pulse per frame with a parity mismatch.
REQ-014 SHALL have port frame_err, output, 1, one-cycle pulse per frame with a stop bit sampled low.
REQ-015 SHALL have port overrun, output, 1, one-cycle pulse per good frame dropped because storage is full.

Function
REQ-016 SHALL synchronise rx through two flops, with both flops resetting to 1; all decisions SHALL use the synchronised value.
REQ-017 SHALL use BAUD_CNT_MAX = CLK_FREQ/UART_BPS (integer divide); the baud counter SHALL count 0..BAUD_CNT_MAX-1 while not IDLE and SHALL hold 0 in IDLE.
REQ-018 SHALL sample each bit by majority of 3 synchronised samples at counts MID-1, MID and MID+1, where MID = BAUD_CNT_MAX/2; the bit decision SHALL be taken at MID+1.
REQ-019 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-020 IDLE->START SHALL occur on a synchronised 1->0 edge of rx.
REQ-021 At the START decision, a sampled 1 SHALL return the FSM to IDLE (glitch reject, no flags); a sampled 0 SHALL go to DATA.
REQ-022 DATA SHALL shift DATA_BITS bits, LSB first, then go to PARITY when PARITY!=0, otherwise to STOP.
REQ-023 PARITY SHALL check the sampled bit: odd mode requires XOR(data, parity bit)=1; even mode requires it to be 0.
REQ-024 STOP SHALL check STOP_BITS stop bits; the first stop bit sampled 0 SHALL pulse frame_err, discard the frame and go to WAIT_HIGH.
REQ-025 WAIT_HIGH SHALL go to IDLE on the first cycle the synchronised rx is 1.
REQ-026 At the last stop decision of a frame with no frame error: a parity error SHALL pulse parity_err and discard the frame; otherwise the word SHALL be pushed, with the FSM going to IDLE in the same cycle.
REQ-027 A push when storage is full SHALL drop the word and pulse overrun; a push and a pop in the same cycle while full SHALL both succeed.
REQ-028 rx_valid SHALL assert in the cycle after the push into empty storage; rx_data SHALL be stable while rx_valid && !rx_ready.
REQ-029 Error pulses SHALL be mutually exclusive per frame and SHALL assert in the cycle after the decision.

Reset
REQ-030 sys_rst SHALL immediately force: FSM IDLE, counters 0, storage empty, rx_valid 0, rx_data 0, parity_err, frame_err and overrun 0.
REQ-031 A frame in progress at reset SHALL be lost; after release, reception SHALL resume only on a new 1->0 edge.

Configuration
REQ-032 With macro UART_RX_FIFO_EN defined, storage SHALL be a FIFO of FIFO_DEPTH words with first-word fall-through on rx_data.
REQ-033 Without UART_RX_FIFO_EN, storage SHALL be a single holding register (full = rx_valid), and FIFO_DEPTH SHALL be ignored; port list unchanged.

Verification (CLK_FREQ 50_000_000, UART_BPS 115200, BAUD_CNT_MAX 434)
REQ-034 SHALL cover: 8N1 frames 0xA5, 0x3C with rx_ready=1 -> two rx_valid words 0xA5, 0x3C, no error pulses.
REQ-035 SHALL cover: PARITY=2, frame 0x07 with parity bit 0 -> parity_err pulse, no push; with parity bit 1 -> word 0x07.
REQ-036 SHALL cover: 100-cycle low glitch on idle rx -> FSM back to IDLE, no flags, no push.
REQ-037 SHALL cover: frame 0x55 with stop bit 0, rx held low 2000 cycles -> one frame_err, no further frames until rx high.
REQ-038 SHALL cover: FIFO enabled, rx_ready=0, 9 frames 0x01..0x09 -> overrun on the 9th; draining yields 0x01..0x08. Non-FIFO build: frame 2 overruns, 0x01 read.
REQ-039 SHALL cover: sys_rst pulsed during data bit 4 -> outputs cleared at once; next full frame 0x81 received correctly.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: UART receiver, majority-of-3 sampling, parity/stop checks.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-word FIFO; otherwise one holding register.
module uart_rx_cfg #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int UART_BPS   = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam int MID = BAUD_CNT_MAX / 2;
  localparam int CW = $clog2(BAUD_CNT_MAX + 1);
  localparam logic [CW-1:0] C_LAST = CW'(BAUD_CNT_MAX - 1);
  localparam logic [CW-1:0] C_S0 = CW'(MID - 1);
  localparam logic [CW-1:0] C_S1 = CW'(MID);
  localparam logic [CW-1:0] C_DEC = CW'(MID + 1);
  localparam logic [3:0] C_LAST_BIT = 4'(DATA_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 || FIFO_DEPTH > 64 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("uart_rx_cfg: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic                 r_rx_s1;
  logic                 r_rx_s2;
  logic                 r_rx_d;
  logic [1:0]           r_arm;
  logic [CW-1:0]        r_cnt;
  logic                 r_smp0;
  logic                 r_smp1;
  logic [3:0]           r_bit_idx;
  logic                 r_stop_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_bad;
  logic                 r_perr;
  logic                 r_ferr;
  logic                 r_ovr;
  logic                 w_fall;
  logic                 w_dec;
  logic                 w_bit;
  logic                 w_par_bad;
  logic                 w_last_stop;
  logic                 w_shift;
  logic                 w_push;
  logic                 w_ferr;
  logic                 w_perr;
  logic                 w_ovr;

  // r_arm blocks edge detection until the reset values have left the sync chain
  assign w_fall = (r_arm == 2'd3) & r_rx_d & ~r_rx_s2;
  assign w_dec = (r_cnt == C_DEC);
  assign w_bit = (r_smp0 & r_smp1) | (r_smp0 & r_rx_s2) | (r_smp1 & r_rx_s2);
  assign w_par_bad = (PARITY == 1) ? ~(^r_shift ^ w_bit) : (^r_shift ^ w_bit);
  assign w_last_stop = (STOP_BITS == 2) ? r_stop_idx : 1'b1;

  assign parity_err = r_perr;
  assign frame_err = r_ferr;
  assign overrun = r_ovr;

  // two-flop synchroniser plus delayed copy for 1->0 edge detection
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_d  <= 1'b0;
      r_arm   <= 2'd0;
    end else begin
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_d  <= r_rx_s2;
      if (r_arm != 2'd3) r_arm <= r_arm + 2'd1;
    end
  end

  // FSM state register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) r_state <= S_IDLE;
    else r_state <= w_next;
  end

  // FSM next state and per-frame decision strobes
  always_comb begin
    w_next  = r_state;
    w_shift = 1'b0;
    w_push  = 1'b0;
    w_ferr  = 1'b0;
    w_perr  = 1'b0;
    unique case (r_state)
      S_IDLE: if (w_fall) w_next = S_START;
      S_START: if (w_dec) w_next = w_bit ? S_IDLE : S_DATA;
      S_DATA: begin
        if (w_dec) begin
          w_shift = 1'b1;
          if (r_bit_idx == C_LAST_BIT)
            w_next = (PARITY != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: if (w_dec) w_next = S_STOP;
      S_STOP: begin
        if (w_dec) begin
          if (!w_bit) begin
            w_ferr = 1'b1;
            w_next = S_WAIT_HIGH;
          end else if (w_last_stop) begin
            if (r_par_bad) w_perr = 1'b1;
            else w_push = 1'b1;
            w_next = S_IDLE;
          end
        end
      end
      S_WAIT_HIGH: if (r_rx_s2) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // baud counter: held at 0 in IDLE, free-running modulo BAUD_CNT_MAX otherwise
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) r_cnt <= '0;
    else if (r_state == S_IDLE || w_next == S_IDLE) r_cnt <= '0;
    else if (r_cnt == C_LAST) r_cnt <= '0;
    else r_cnt <= r_cnt + CW'(1);
  end

  // bit samples, data shifter, bit/stop indices and latched parity result
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_smp0     <= 1'b1;
      r_smp1     <= 1'b1;
      r_shift    <= '0;
      r_bit_idx  <= 4'd0;
      r_stop_idx <= 1'b0;
      r_par_bad  <= 1'b0;
    end else begin
      if (r_cnt == C_S0) r_smp0 <= r_rx_s2;
      if (r_cnt == C_S1) r_smp1 <= r_rx_s2;
      if (w_shift) r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
      if (r_state != S_DATA) r_bit_idx <= 4'd0;
      else if (w_shift) r_bit_idx <= r_bit_idx + 4'd1;
      if (r_state != S_STOP) r_stop_idx <= 1'b0;
      else if (w_dec) r_stop_idx <= 1'b1;
      if (r_state == S_IDLE) r_par_bad <= 1'b0;
      else if (r_state == S_PARITY && w_dec) r_par_bad <= w_par_bad;
    end
  end

  // error pulses land one cycle after the decision
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_perr <= 1'b0;
      r_ferr <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      r_perr <= w_perr;
      r_ferr <= w_ferr;
      r_ovr  <= w_ovr;
    end
  end

`ifdef UART_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] C_DEPTH = (AW+1)'(FIFO_DEPTH);

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [AW:0]          r_count;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_wr;

  assign w_full = (r_count == C_DEPTH);
  assign rx_valid = (r_count != '0);
  assign w_pop = rx_valid & rx_ready;
  assign w_wr = w_push & (~w_full | w_pop);
  assign w_ovr = w_push & w_full & ~w_pop;
  assign rx_data = rx_valid ? r_mem[r_rd_ptr] : '0;

  // storage array; contents only visible while r_count says so
  always_ff @(posedge sys_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= r_shift;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_wr && !w_pop) r_count <= r_count + (AW+1)'(1);
      else if (!w_wr && w_pop) r_count <= r_count - (AW+1)'(1);
    end
  end
`else
  logic [DATA_BITS-1:0] r_hold;
  logic                 r_valid;
  logic                 w_pop;
  logic                 w_wr;

  assign rx_valid = r_valid;
  assign rx_data = r_hold;
  assign w_pop = r_valid & rx_ready;
  assign w_wr = w_push & (~r_valid | w_pop);
  assign w_ovr = w_push & r_valid & ~w_pop;

  // single holding register; full whenever rx_valid is set
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_hold  <= '0;
      r_valid <= 1'b0;
    end else if (w_wr) begin
      r_hold  <= r_shift;
      r_valid <= 1'b1;
    end else if (w_pop) begin
      r_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed frames against a queue-based receiver model.
// Second instance (even parity) exercises parity checking in parallel.
module tb_uart_rx_cfg;
  localparam int BIT = 434;
`ifdef UART_RX_FIFO_EN
  localparam int CAP = 8;
`else
  localparam int CAP = 1;
`endif

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, parity_err, frame_err, overrun;

  logic       rst_p = 1'b1;
  logic       rx_p = 1'b1;
  logic       ready_p = 1'b1;
  logic [7:0] data_p;
  logic       valid_p, perr_p, ferr_p, ovr_p;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_w[$];
  logic [7:0] got_w[$];
  int exp_evt[$];
  int occ = 0;
  int n_ferr = 0;
  int n_ovr = 0;
  logic [7:0] got_p[$];
  int n_perr_p = 0;
  int n_other_p = 0;
  bit p_done = 1'b0;

  always #10 sys_clk = ~sys_clk;

  uart_rx_cfg #(
    .CLK_FREQ(50_000_000), .UART_BPS(115200), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(8)
  ) u_dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .rx(rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun)
  );

  uart_rx_cfg #(
    .CLK_FREQ(50_000_000), .UART_BPS(115200), .DATA_BITS(8),
    .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(8)
  ) u_par (
    .sys_clk(sys_clk), .sys_rst(rst_p), .rx(rx_p),
    .rx_data(data_p), .rx_valid(valid_p), .rx_ready(ready_p),
    .parity_err(perr_p), .frame_err(ferr_p), .overrun(ovr_p)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic evt(input int t, input string nm);
    n_cmp++;
    if (exp_evt.size() == 0 || exp_evt[0] != t) begin
      n_bad++;
      $display("FAIL %s: pulse seen, expected none", nm);
    end else begin
      void'(exp_evt.pop_front());
    end
  endtask

  // frame outcome from the line rules: 1 parity, 2 frame, 3 overrun
  function automatic void model_frame(input bit stop_v, input logic [7:0] d);
    if (!stop_v) exp_evt.push_back(2);
    else if (occ == CAP) exp_evt.push_back(3);
    else begin
      exp_w.push_back(d);
      occ++;
    end
  endfunction

  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (rx_valid) begin
        if (exp_w.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_word: got %0h expected none", rx_data);
        end else begin
          chk("rx_data", 32'(rx_data), 32'(exp_w[0]));
          if (rx_ready) begin
            got_w.push_back(rx_data);
            void'(exp_w.pop_front());
            occ--;
          end
        end
      end
      if (parity_err) evt(1, "parity_err");
      if (frame_err) begin
        n_ferr++;
        evt(2, "frame_err");
      end
      if (overrun) begin
        n_ovr++;
        evt(3, "overrun");
      end
    end
  end

  always @(negedge sys_clk) begin
    if (!rst_p) begin
      if (valid_p && ready_p) got_p.push_back(data_p);
      if (perr_p) n_perr_p++;
      if (ferr_p || ovr_p) n_other_p++;
    end
  end

  task automatic drv(input bit on_p, input bit b);
    if (on_p) rx_p = b;
    else rx = b;
  endtask

  task automatic send_frame(input bit on_p, input logic [7:0] d,
                            input bit has_par, input bit par_bit,
                            input bit stop_v, input bit upd);
    drv(on_p, 1'b0);
    repeat (BIT) @(posedge sys_clk);
    for (int i = 0; i < 8; i++) begin
      drv(on_p, d[i]);
      repeat (BIT) @(posedge sys_clk);
    end
    if (has_par) begin
      drv(on_p, par_bit);
      repeat (BIT) @(posedge sys_clk);
    end
    drv(on_p, stop_v);
    repeat (120) @(posedge sys_clk);
    if (upd) model_frame(stop_v, d);
    repeat (BIT - 120) @(posedge sys_clk);
  endtask

  task automatic wait_drain(input string nm);
    int t = 0;
    while ((exp_w.size() != 0 || exp_evt.size() != 0) && t < 20000) begin
      @(posedge sys_clk);
      t++;
    end
    n_cmp++;
    if (t >= 20000) begin
      n_bad++;
      $display("FAIL %s: %0d words %0d pulses outstanding, expected 0",
               nm, exp_w.size(), exp_evt.size());
    end
  endtask

  task automatic parity_seq();
    repeat (3) @(posedge sys_clk);
    rst_p = 1'b0;
    repeat (20) @(posedge sys_clk);
    send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (300) @(posedge sys_clk);
    chk("par_bad_pulse", 32'(n_perr_p), 1);
    chk("par_bad_nopush", 32'(got_p.size()), 0);
    send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (300) @(posedge sys_clk);
    chk("par_ok_push", 32'(got_p.size()), 1);
    chk("par_ok_word", 32'(got_p[0]), 32'h07);
    chk("par_pulses", 32'(n_perr_p), 1);
    chk("par_other", 32'(n_other_p), 0);
    p_done = 1'b1;
  endtask

  initial begin
    fork
      parity_seq();
    join_none
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_valid", 32'(rx_valid), 0);
    chk("rst_data", 32'(rx_data), 0);
    chk("rst_perr", 32'(parity_err), 0);
    chk("rst_ferr", 32'(frame_err), 0);
    chk("rst_ovr", 32'(overrun), 0);
    sys_rst = 1'b0;
    repeat (20) @(posedge sys_clk);

    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1);
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (50) @(posedge sys_clk);
    wait_drain("n81_drain");
    chk("n81_word0", 32'(got_w[0]), 32'hA5);
    chk("n81_word1", 32'(got_w[1]), 32'h3C);

    rx = 1'b0;
    repeat (100) @(posedge sys_clk);
    rx = 1'b1;
    repeat (1000) @(posedge sys_clk);
    chk("glitch_words", 32'(got_w.size()), 2);
    wait_drain("glitch_drain");

    send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (2000) @(posedge sys_clk);
    chk("ferr_count", 32'(n_ferr), 1);
    rx = 1'b1;
    repeat (50) @(posedge sys_clk);
    wait_drain("ferr_drain");
    chk("ferr_words", 32'(got_w.size()), 2);

    @(posedge sys_clk);
    #1 rx_ready = 1'b0;
    for (int i = 1; i <= CAP + 1; i++)
      send_frame(1'b0, 8'(i), 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (100) @(posedge sys_clk);
    chk("ovr_count", 32'(n_ovr), 1);
    chk("ovr_head", 32'(rx_data), 32'h01);
    @(posedge sys_clk);
    #1 rx_ready = 1'b1;
    wait_drain("ovr_drain");
    chk("ovr_words", 32'(got_w.size()), 32'(2 + CAP));
    for (int k = 0; k < CAP; k++)
      chk("ovr_order", 32'(got_w[2 + k]), 32'(k + 1));

    @(posedge sys_clk);
    #1 rx_ready = 1'b0;
    send_frame(1'b0, 8'h42, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (20) @(posedge sys_clk);
    chk("pre_rst_valid", 32'(rx_valid), 1);
    rx = 1'b0;
    repeat (5 * BIT + 10) @(posedge sys_clk);
    #1 sys_rst = 1'b1;
    #1;
    chk("rst_mid_valid", 32'(rx_valid), 0);
    chk("rst_mid_data", 32'(rx_data), 0);
    exp_w.delete();
    exp_evt.delete();
    occ = 0;
    repeat (3) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    rx_ready = 1'b1;
    repeat (BIT - 14) @(posedge sys_clk);
    rx = 1'b1;
    repeat (4 * BIT + 200) @(posedge sys_clk);
    chk("rst_no_word", 32'(got_w.size()), 32'(2 + CAP));
    send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (50) @(posedge sys_clk);
    wait_drain("rst_drain");
    chk("rst_next_word", 32'(got_w[got_w.size() - 1]), 32'h81);

    for (int t = 0; t < 50000 && !p_done; t++) @(posedge sys_clk);
    chk("par_done", 32'(p_done), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
